usart_transmitter: RTL

USART transmit path: a two-level buffer (transmit data register, then shift register) feeding a frame serializer. The serializer drives TXD with start, data (LSB first), optional parity and stop bits, advancing one bit per baud tick. It sits between the MCU register interface and the TXD pin, mirroring the receive buffer chain, and exports the UDRE (data register empty) and TXC (transmit complete) flags.

---
 rtl/usart_transmitter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/usart_transmitter.sv
// USART transmit path: UDR holding buffer -> shift register -> frame serializer on TXD.
// Define USART_TX_PARITY_EN to compile in parity generation and the PARITY state.
module usart_transmitter (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_baud_tick,
  input  logic       i_tx_enable,
  input  logic       i_mcu_write,
  input  logic [7:0] i_udr,
  input  logic       i_txb8,
  input  logic [2:0] i_char_size,
  input  logic [1:0] i_parity_mode,
  input  logic       i_stop_bits,
  input  logic       i_txc_clear,
  output logic       o_txd,
  output logic       o_udre,
  output logic       o_txc,
  output logic       o_busy,
  output logic [2:0] o_state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
`ifdef USART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP1  = 3'd5,
    S_STOP2  = 3'd6
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] buf_q, buf_d;
  logic       buf_valid_q, buf_valid_d;
  logic [8:0] shift_q, shift_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] last_q, last_d;
  logic       stop2_q, stop2_d;
  logic       txd_q, txd_d;
  logic       txc_q, txc_d;
  logic       load, end_frame, txc_set;
  logic [3:0] load_last;

  // Index of the last data bit (N-1); unused codes 4..6 behave as 8 bits.
  function automatic logic [3:0] last_idx(input logic [2:0] cs);
    case (cs)
      3'd0:    last_idx = 4'd4;
      3'd1:    last_idx = 4'd5;
      3'd2:    last_idx = 4'd6;
      3'd7:    last_idx = 4'd8;
      default: last_idx = 4'd7;
    endcase
  endfunction

`ifdef USART_TX_PARITY_EN
  logic       par_en_q, par_en_d;
  logic       par_bit_q, par_bit_d;
  logic [8:0] data_mask;

  always_comb begin
    data_mask = '0;
    for (int i = 0; i < 9; i++) data_mask[i] = (4'(i) <= load_last);
  end
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^i_parity_mode;
`endif

  // MCU write handshake: i_mcu_write is a one-cycle strobe accepted only when
  // o_udre=1 at that edge; a strobe seen with o_udre=0 is silently discarded.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    stop2_d     = stop2_q;
    txd_d       = txd_q;
    load        = 1'b0;
    end_frame   = 1'b0;
    txc_set     = 1'b0;
    load_last   = last_idx(i_char_size);
`ifdef USART_TX_PARITY_EN
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
`endif
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (buf_valid_q && i_tx_enable) begin
          load    = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: if (i_baud_tick) begin
        state_d = S_START;
        txd_d   = 1'b0;
      end
      S_START: if (i_baud_tick) begin
        state_d = S_DATA;
        txd_d   = shift_q[0];
        shift_d = {1'b0, shift_q[8:1]};
        cnt_d   = '0;
      end
      S_DATA: if (i_baud_tick) begin
        if (cnt_q < last_q) begin
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[8:1]};
          cnt_d   = cnt_q + 4'd1;
        end
`ifdef USART_TX_PARITY_EN
        else if (par_en_q) begin
          state_d = S_PARITY;
          txd_d   = par_bit_q;
        end
`endif
        else begin
          state_d = S_STOP1;
          txd_d   = 1'b1;
        end
      end
`ifdef USART_TX_PARITY_EN
      S_PARITY: if (i_baud_tick) begin
        state_d = S_STOP1;
        txd_d   = 1'b1;
      end
`endif
      S_STOP1: if (i_baud_tick) begin
        if (stop2_q) begin
          state_d = S_STOP2;
          txd_d   = 1'b1;
        end else begin
          end_frame = 1'b1;
        end
      end
      S_STOP2: if (i_baud_tick) end_frame = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // A waiting byte chains straight into the next start bit with no idle gap.
    if (end_frame) begin
      if (buf_valid_q && i_tx_enable) begin
        load    = 1'b1;
        state_d = S_START;
        txd_d   = 1'b0;
      end else begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        txc_set = 1'b1;
      end
    end

    if (load) begin
      buf_valid_d = 1'b0;
      shift_d     = buf_q;
      last_d      = load_last;
      stop2_d     = i_stop_bits;
`ifdef USART_TX_PARITY_EN
      par_en_d    = i_parity_mode[1];
      par_bit_d   = (^(buf_q & data_mask)) ^ i_parity_mode[0];
`endif
    end

    if (i_mcu_write && !buf_valid_q) begin
      buf_valid_d = 1'b1;
      buf_d       = {i_txb8, i_udr};
    end

    txc_d = txc_set ? 1'b1 : (i_txc_clear ? 1'b0 : txc_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      last_q      <= '0;
      stop2_q     <= 1'b0;
      txd_q       <= 1'b1;
      txc_q       <= 1'b0;
`ifdef USART_TX_PARITY_EN
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      stop2_q     <= stop2_d;
      txd_q       <= txd_d;
      txc_q       <= txc_d;
`ifdef USART_TX_PARITY_EN
      par_en_q    <= par_en_d;
      par_bit_q   <= par_bit_d;
`endif
    end
  end

  assign o_txd       = txd_q;
  assign o_udre      = !buf_valid_q;
  assign o_txc       = txc_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_state_dbg = state_q;

endmodule
